// File: rtl/mpmc10_pkg.sv
// mpmc10_pkg
//   Shared definitions for the mpmc10 controller and its DDR3 app-interface
//   responder: command codes, the queued command record and the responder
//   state encoding.
package mpmc10_pkg;

  // MIG app_cmd encodings
  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  // Width of the app_addr field carried in a queued command
  localparam int MPMC10_ADDR_W = 29;

  // One accepted app command as held in the responder command FIFO
  typedef struct packed {
    logic [2:0]               cmd;
    logic [MPMC10_ADDR_W-1:0] addr;
  } mpmc10_app_cmd_t;

  // Responder top-level state
  typedef enum logic {
    RSP_CALIB = 1'b0,
    RSP_RUN   = 1'b1
  } mpmc10_rsp_state_t;

endpackage

// File: rtl/mpmc10_rsp_fifo.sv
// mpmc10_rsp_fifo
//   Small synchronous FIFO used by the app responder for commands and
//   write data. DEPTH must be a power of two (>= 2). Pushes while full and
//   pops while empty are ignored. Storage is not reset.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   push, din       write strobe and data
//   pop, dout       read strobe and head-of-queue data (combinational)
//   full, empty     occupancy flags
//   count           current occupancy (0..DEPTH)
module mpmc10_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == {(AW+1){1'b0}});
  assign count     = count_r;
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign dout      = mem_r[rd_ptr_r];

  // Pointer and occupancy tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_r + (AW+1)'(push_ok_s) - (AW+1)'(pop_ok_s);
    end
  end

  // Entry storage (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

endmodule

// File: rtl/mpmc10_app_rsp.sv
// mpmc10_app_rsp
//   Memory-side responder for the DDR3 MIG user (app) interface. Emulates
//   calibration, accepts commands and write data into in-order queues,
//   executes one command per cycle against a small on-chip backing store,
//   and returns read beats through a fixed-latency pipe.
//   Optional build macro: MPMC10_RSP_BACKPRESSURE_EN adds pseudo-random
//   stalls on app_rdy / app_wdf_rdy from a 16-bit LFSR.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   init_calib_complete  calibration done (sticky until reset)
//   app_en/app_cmd/app_addr/app_rdy              command handshake
//   app_wdf_wren/_data/_mask/_end/app_wdf_rdy    write-data handshake
//   app_rd_data/_valid/_end                      read return
//   err                  sticky: unknown command or app_wdf_end = 0
module mpmc10_app_rsp
  import mpmc10_pkg::*;
#(
  parameter int ADDR_W    = 29,
  parameter int DATA_W    = 128,
  parameter int MEM_AW    = 10,
  parameter int QDEPTH    = 4,
  parameter int RD_LAT    = 6,
  parameter int CALIB_CYC = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                init_calib_complete,
  input  logic                app_en,
  input  logic [2:0]          app_cmd,
  input  logic [ADDR_W-1:0]   app_addr,
  output logic                app_rdy,
  input  logic                app_wdf_wren,
  input  logic [DATA_W-1:0]   app_wdf_data,
  input  logic [DATA_W/8-1:0] app_wdf_mask,
  input  logic                app_wdf_end,
  output logic                app_wdf_rdy,
  output logic [DATA_W-1:0]   app_rd_data,
  output logic                app_rd_data_valid,
  output logic                app_rd_data_end,
  output logic                err
);

  localparam int NB    = DATA_W / 8;
  localparam int CW    = $clog2(QDEPTH) + 1;
  localparam int CNT_W = $clog2(CALIB_CYC + 1);
  localparam int WDF_W = DATA_W + NB;

  // Queues
  mpmc10_app_cmd_t   cmd_in_s;
  mpmc10_app_cmd_t   cmd_head_s;
  logic              cmd_push_s;
  logic              cmd_pop_s;
  logic              cmd_full_s;
  logic              cmd_empty_s;
  logic [CW-1:0]     cmd_count_s;
  logic [CW-1:0]     cmd_cnt_nxt_s;
  logic              cmd_full_nxt_s;

  logic [WDF_W-1:0]  wdf_in_s;
  logic [WDF_W-1:0]  wdf_head_s;
  logic              wdf_push_s;
  logic              wdf_pop_s;
  logic              wdf_full_s;
  logic              wdf_empty_s;
  logic [CW-1:0]     wdf_count_s;
  logic [CW-1:0]     wdf_cnt_nxt_s;
  logic              wdf_full_nxt_s;
  logic [DATA_W-1:0] wdf_data_s;
  logic [NB-1:0]     wdf_mask_s;

  // Execute stage
  logic              wr_exec_s;
  logic              rd_exec_s;
  logic              bad_cmd_s;
  logic [MEM_AW-1:0] mem_idx_s;
  logic              unused_addr_s;

  // Control state and registered outputs
  mpmc10_rsp_state_t state_r;
  logic [CNT_W-1:0]  calib_cnt_r;
  logic              calib_done_r;
  logic              app_rdy_r;
  logic              app_wdf_rdy_r;
  logic              err_r;
  logic              cmd_gate_s;
  logic              wdf_gate_s;

  // Backing store and read pipe
  logic [DATA_W-1:0]              mem_r [2**MEM_AW];
  logic [RD_LAT-1:0]              vpipe_r;
  logic [RD_LAT-1:0][DATA_W-1:0]  dpipe_r;

  assign cmd_in_s   = {app_cmd, MPMC10_ADDR_W'(app_addr)};
  assign cmd_push_s = app_en & app_rdy_r;
  assign wdf_in_s   = {app_wdf_mask, app_wdf_data};
  assign wdf_push_s = app_wdf_wren & app_wdf_rdy_r;
  assign wdf_data_s = wdf_head_s[DATA_W-1:0];
  assign wdf_mask_s = wdf_head_s[WDF_W-1:DATA_W];

  mpmc10_rsp_fifo #(
    .WIDTH ($bits(mpmc10_app_cmd_t)),
    .DEPTH (QDEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_push_s),
    .din   (cmd_in_s),
    .pop   (cmd_pop_s),
    .dout  (cmd_head_s),
    .full  (cmd_full_s),
    .empty (cmd_empty_s),
    .count (cmd_count_s)
  );

  mpmc10_rsp_fifo #(
    .WIDTH (WDF_W),
    .DEPTH (QDEPTH)
  ) u_wdf_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wdf_push_s),
    .din   (wdf_in_s),
    .pop   (wdf_pop_s),
    .dout  (wdf_head_s),
    .full  (wdf_full_s),
    .empty (wdf_empty_s),
    .count (wdf_count_s)
  );

  // Ready flags are registered from next-cycle occupancy, so a pop in the
  // same cycle as a full flag only reopens the port one cycle later.
  assign cmd_cnt_nxt_s  = cmd_count_s + CW'(cmd_push_s) - CW'(cmd_pop_s);
  assign wdf_cnt_nxt_s  = wdf_count_s + CW'(wdf_push_s) - CW'(wdf_pop_s);
  assign cmd_full_nxt_s = (cmd_cnt_nxt_s == CW'(QDEPTH));
  assign wdf_full_nxt_s = (wdf_cnt_nxt_s == CW'(QDEPTH));

  // Store index ignores the sub-beat bits and anything above the store size
  assign mem_idx_s     = cmd_head_s.addr[MEM_AW+2:3];
  assign unused_addr_s = ^{cmd_head_s.addr[MPMC10_ADDR_W-1:MEM_AW+3],
                           cmd_head_s.addr[2:0], cmd_full_s, wdf_full_s};

`ifdef MPMC10_RSP_BACKPRESSURE_EN
  logic [15:0] lfsr_r;
  logic [15:0] lfsr_nxt_s;

  assign lfsr_nxt_s = {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
  // Gate on the value the LFSR holds in the cycle the ready flag is visible
  assign cmd_gate_s = (lfsr_nxt_s[1:0] != 2'b00);
  assign wdf_gate_s = (lfsr_nxt_s[3:2] != 2'b00);

  // Stall pattern generator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r <= 16'hACE1;
    end else begin
      lfsr_r <= lfsr_nxt_s;
    end
  end
`else
  assign cmd_gate_s = 1'b1;
  assign wdf_gate_s = 1'b1;
`endif

  // Execute-stage decode of the command at the head of the queue
  always_comb begin
    cmd_pop_s = 1'b0;
    wdf_pop_s = 1'b0;
    wr_exec_s = 1'b0;
    rd_exec_s = 1'b0;
    bad_cmd_s = 1'b0;
    if (!cmd_empty_s) begin
      case (cmd_head_s.cmd)
        CMD_WRITE: begin
          // A write waits at the head until its data beat has arrived
          if (!wdf_empty_s) begin
            cmd_pop_s = 1'b1;
            wdf_pop_s = 1'b1;
            wr_exec_s = 1'b1;
          end else begin
            cmd_pop_s = 1'b0;
          end
        end
        CMD_READ: begin
          cmd_pop_s = 1'b1;
          rd_exec_s = 1'b1;
        end
        default: begin
          cmd_pop_s = 1'b1;
          bad_cmd_s = 1'b1;
        end
      endcase
    end else begin
      cmd_pop_s = 1'b0;
    end
  end

  // Calibration / run FSM with registered ready and calib outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= RSP_CALIB;
      calib_cnt_r   <= {CNT_W{1'b0}};
      calib_done_r  <= 1'b0;
      app_rdy_r     <= 1'b0;
      app_wdf_rdy_r <= 1'b0;
    end else begin
      case (state_r)
        RSP_CALIB: begin
          if (calib_cnt_r == CNT_W'(CALIB_CYC - 1)) begin
            state_r       <= RSP_RUN;
            calib_done_r  <= 1'b1;
            app_rdy_r     <= ~cmd_full_nxt_s & cmd_gate_s;
            app_wdf_rdy_r <= ~wdf_full_nxt_s & wdf_gate_s;
          end else begin
            calib_cnt_r   <= calib_cnt_r + CNT_W'(1);
            app_rdy_r     <= 1'b0;
            app_wdf_rdy_r <= 1'b0;
          end
        end
        RSP_RUN: begin
          calib_done_r  <= 1'b1;
          app_rdy_r     <= ~cmd_full_nxt_s & cmd_gate_s;
          app_wdf_rdy_r <= ~wdf_full_nxt_s & wdf_gate_s;
        end
        default: begin
          state_r       <= RSP_CALIB;
          calib_cnt_r   <= {CNT_W{1'b0}};
          calib_done_r  <= 1'b0;
          app_rdy_r     <= 1'b0;
          app_wdf_rdy_r <= 1'b0;
        end
      endcase
    end
  end

  // Sticky protocol error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | bad_cmd_s | (wdf_push_s & ~app_wdf_end);
    end
  end

  // Backing store byte-enable writes (contents survive reset)
  always_ff @(posedge clk) begin
    if (wr_exec_s) begin
      for (int b = 0; b < NB; b++) begin
        if (!wdf_mask_s[b]) begin
          mem_r[mem_idx_s][8*b +: 8] <= wdf_data_s[8*b +: 8];
        end
      end
    end
  end

  // Read return pipe; stage 0 holds the word read in the execute cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe_r <= {RD_LAT{1'b0}};
      dpipe_r <= {(RD_LAT*DATA_W){1'b0}};
    end else begin
      vpipe_r[0] <= rd_exec_s;
      dpipe_r[0] <= rd_exec_s ? mem_r[mem_idx_s] : {DATA_W{1'b0}};
      for (int k = 1; k < RD_LAT; k++) begin
        vpipe_r[k] <= vpipe_r[k-1];
        dpipe_r[k] <= dpipe_r[k-1];
      end
    end
  end

  assign init_calib_complete = calib_done_r;
  assign app_rdy             = app_rdy_r;
  assign app_wdf_rdy         = app_wdf_rdy_r;
  assign app_rd_data         = dpipe_r[RD_LAT-1];
  assign app_rd_data_valid   = vpipe_r[RD_LAT-1];
  assign app_rd_data_end     = vpipe_r[RD_LAT-1];
  assign err                 = err_r;

endmodule

// File: tb/tb_mpmc10_app_rsp.sv
// tb_mpmc10_app_rsp
//   Directed bench for mpmc10_app_rsp: table of masked write / read-back
//   vectors plus hand-written sequences for calibration, latency, data
//   ordering, queue-full backpressure, bad commands and mid-flight reset.
module tb_mpmc10_app_rsp;
  import mpmc10_pkg::*;

  localparam int ADDR_W    = 29;
  localparam int DATA_W    = 128;
  localparam int MEM_AW    = 10;
  localparam int QDEPTH    = 4;
  localparam int RD_LAT    = 6;
  localparam int CALIB_CYC = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              init_calib_complete;
  logic              app_en;
  logic [2:0]        app_cmd;
  logic [ADDR_W-1:0] app_addr;
  logic              app_rdy;
  logic              app_wdf_wren;
  logic [DATA_W-1:0] app_wdf_data;
  logic [15:0]       app_wdf_mask;
  logic              app_wdf_end;
  logic              app_wdf_rdy;
  logic [DATA_W-1:0] app_rd_data;
  logic              app_rd_data_valid;
  logic              app_rd_data_end;
  logic              err;

  mpmc10_app_rsp #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MEM_AW    (MEM_AW),
    .QDEPTH    (QDEPTH),
    .RD_LAT    (RD_LAT),
    .CALIB_CYC (CALIB_CYC)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .init_calib_complete (init_calib_complete),
    .app_en              (app_en),
    .app_cmd             (app_cmd),
    .app_addr            (app_addr),
    .app_rdy             (app_rdy),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .app_rd_data_end     (app_rd_data_end),
    .err                 (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int vcount   = 0;
  logic [127:0] rdq[$];

  typedef struct {
    logic [28:0]  wr_addr;
    logic [28:0]  rd_addr;
    logic [127:0] pre;
    logic [127:0] data;
    logic [15:0]  mask;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Collect every returned read beat; end must accompany valid
  always @(negedge clk) begin
    if (app_rd_data_valid) begin
      rdq.push_back(app_rd_data);
      vcount++;
      chk("rd_end", {127'd0, app_rd_data_end}, 128'd1);
    end
  end

  task automatic send_cmd(input logic [2:0] cmd, input logic [28:0] addr);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    app_en = 1'b1; app_cmd = cmd; app_addr = addr;
    for (int n = 0; n < 200; n++) begin
      ok = app_rdy;
      @(posedge clk);
      if (ok) break;
      @(negedge clk);
    end
    #1 app_en = 1'b0;
    chk("cmd_accept", 128'(ok), 128'd1);
  endtask

  task automatic send_wdf(input logic [127:0] data, input logic [15:0] mask);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    app_wdf_wren = 1'b1; app_wdf_data = data; app_wdf_mask = mask; app_wdf_end = 1'b1;
    for (int n = 0; n < 200; n++) begin
      ok = app_wdf_rdy;
      @(posedge clk);
      if (ok) break;
      @(negedge clk);
    end
    #1 app_wdf_wren = 1'b0;
    chk("wdf_accept", 128'(ok), 128'd1);
  endtask

  task automatic get_rd(input string name, input logic [127:0] exp);
    int n;
    n = 0;
    while (rdq.size() == 0 && n < 100) begin
      @(negedge clk);
      #1 n++;
    end
    if (rdq.size() != 0) begin
      chk(name, rdq.pop_front(), exp);
    end else begin
      chk({name, "_timeout"}, 128'd0, 128'd1);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit rdy_seen;
    int vc0;
    logic [127:0] d0, d1, d2;

    vecs[0] = '{29'h48, 29'h48, {16{8'hFF}}, 128'h0123456789ABCDEF_FEDCBA9876543210,
                16'h00FF, 128'h0123456789ABCDEF_FFFFFFFFFFFFFFFF};
    vecs[1] = '{29'h50, 29'h50, {16{8'hFF}}, 128'h0, 16'hFF00,
                128'hFFFFFFFFFFFFFFFF_0000000000000000};
    vecs[2] = '{29'h58, 29'h58, {16{8'hAA}}, {16{8'h55}}, 16'hAAAA, {8{16'hAA55}}};
    vecs[3] = '{29'h2008, 29'h000F, 128'h0, 128'hDEADBEEFCAFEF00D123456789ABCDEF0,
                16'h0000, 128'hDEADBEEFCAFEF00D123456789ABCDEF0};
    vecs[4] = '{29'h60, 29'h60, {16{8'h11}}, {16{8'h99}}, 16'hFFFF, {16{8'h11}}};
    vecs[5] = '{29'h1FF8, 29'h1FF8, 128'h0, 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0,
                16'h0001, 128'h0F1E2D3C4B5A69788796A5B4C3D2E100};

    rst_n = 1'b0; app_en = 1'b0; app_cmd = 3'b000; app_addr = 29'h0;
    app_wdf_wren = 1'b0; app_wdf_data = 128'h0; app_wdf_mask = 16'h0; app_wdf_end = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_calib", 128'(init_calib_complete), 128'd0);
    chk("rst_rdy", 128'(app_rdy), 128'd0);
    chk("rst_wdf_rdy", 128'(app_wdf_rdy), 128'd0);
    chk("rst_valid", 128'(app_rd_data_valid), 128'd0);
    chk("rst_err", 128'(err), 128'd0);
    chk("rst_rd_data", app_rd_data, 128'd0);

    // Calibration latency, ports closed until done
    @(negedge clk);
    rst_n = 1'b1;
    n = 0; rdy_seen = 1'b0;
    while (!init_calib_complete && n < 1000) begin
      @(posedge clk);
      #1 n++;
      if (!init_calib_complete && (app_rdy || app_wdf_rdy)) rdy_seen = 1'b1;
    end
    chk("calib_latency", 128'(n), 128'(CALIB_CYC));
    chk("rdy_before_calib", 128'(rdy_seen), 128'd0);
    chk("rdy_after_calib", 128'(app_rdy), 128'd1);
    chk("wdf_rdy_after_calib", 128'(app_wdf_rdy), 128'd1);

    // Basic write then read with latency measurement
    send_cmd(CMD_WRITE, 29'h40);
    send_wdf(128'h0123456789ABCDEF0123456789ABCDEF, 16'h0000);
    repeat (4) @(negedge clk);
    send_cmd(CMD_READ, 29'h40);
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!app_rd_data_valid && n < 50);
    chk("rd_latency", 128'(n), 128'(RD_LAT));
    @(posedge clk);
    #1 chk("rd_single_beat", 128'(app_rd_data_valid), 128'd0);
    get_rd("rd_basic", 128'h0123456789ABCDEF0123456789ABCDEF);

    // Table of masked writes and read-backs
    for (int i = 0; i < 6; i++) begin
      send_cmd(CMD_WRITE, vecs[i].wr_addr);
      send_wdf(vecs[i].pre, 16'h0000);
      send_cmd(CMD_WRITE, vecs[i].wr_addr);
      send_wdf(vecs[i].data, vecs[i].mask);
      send_cmd(CMD_READ, vecs[i].rd_addr);
      get_rd($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Write data ahead of its commands
    d0 = {16{8'hA1}}; d1 = {16{8'hB2}}; d2 = {16{8'hC3}};
    send_wdf(d0, 16'h0000);
    send_wdf(d1, 16'h0000);
    send_wdf(d2, 16'h0000);
    send_cmd(CMD_WRITE, 29'h0);
    send_cmd(CMD_WRITE, 29'h8);
    send_cmd(CMD_WRITE, 29'h10);
    send_cmd(CMD_READ, 29'h0);
    send_cmd(CMD_READ, 29'h8);
    send_cmd(CMD_READ, 29'h10);
    get_rd("early_wdf0", d0);
    get_rd("early_wdf1", d1);
    get_rd("early_wdf2", d2);

    // Command queue full with no data: ready drops, then recovers
    for (int i = 0; i < QDEPTH; i++) send_cmd(CMD_WRITE, 29'(29'h100 + 8 * i));
    @(negedge clk);
    chk("rdy_full", 128'(app_rdy), 128'd0);
    repeat (3) @(negedge clk);
    chk("rdy_full_hold", 128'(app_rdy), 128'd0);
    send_wdf({8{16'h5000}}, 16'h0000);
    n = 0;
    while (!app_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rdy_return", 128'(app_rdy), 128'd1);
    for (int i = 1; i < QDEPTH; i++) send_wdf({8{16'(16'h5000 + i)}}, 16'h0000);
    send_cmd(CMD_WRITE, 29'h120);
    send_wdf({8{16'h5004}}, 16'h0000);
    vc0 = vcount;
    for (int i = 0; i <= QDEPTH; i++) send_cmd(CMD_READ, 29'(29'h100 + 8 * i));
    for (int i = 0; i <= QDEPTH; i++) get_rd($sformatf("full_rd%0d", i), {8{16'(16'h5000 + i)}});
    repeat (RD_LAT + 10) @(negedge clk);
    chk("full_beat_count", 128'(vcount - vc0), 128'(QDEPTH + 1));

    // Unknown command code: flagged, no read beat
    vc0 = vcount;
    chk("err_before_bad", 128'(err), 128'd0);
    send_cmd(3'b111, 29'h0);
    repeat (RD_LAT + 4) @(negedge clk);
    chk("err_bad_cmd", 128'(err), 128'd1);
    chk("bad_cmd_no_valid", 128'(vcount - vc0), 128'd0);

    // Reset with reads in flight
    send_cmd(CMD_READ, 29'h0);
    send_cmd(CMD_READ, 29'h8);
    @(negedge clk);
    vc0 = vcount;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_err", 128'(err), 128'd0);
    chk("rst_mid_valid", 128'(app_rd_data_valid), 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (RD_LAT + 10) @(negedge clk);
    chk("rst_mid_no_valid", 128'(vcount - vc0), 128'd0);
    chk("rst_mid_recalib", 128'(init_calib_complete), 128'd0);
    chk("rst_mid_err_clear", 128'(err), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
